cache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache with its own backing RAM.

---
 rtl/cache_nway_wb_if.sv | 24 ++
 rtl/cache_nway_wb.sv | 185 ++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_wb_if.sv
// Request/response bus between a simple load/store master and cache_nway_wb.
interface cache_nway_wb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_hit
    );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement,
// a latency-modelled backing RAM and saturating hit/miss counters.
module cache_nway_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int SETS    = 4,
    parameter int WAYS    = 2,
    parameter int MEM_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_nway_wb_if.slave        bus,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_image();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
        return m;
    endfunction

    // Backing RAM keeps its contents across reset; it powers up holding its own addresses.
    mem_t mem = mem_image();

    state_t state, next_state;

    logic              valid [SETS][WAYS];
    logic              dirty [SETS][WAYS];
    logic [TAG_W-1:0]  tag   [SETS][WAYS];
    logic [DATA_W-1:0] data  [SETS][WAYS];
    logic [WAY_W-1:0]  age   [SETS][WAYS];

    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [WAY_W-1:0]  way_sel;
    logic              hit_reg;
    logic [CNT_W-1:0]  lat_cnt;

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              lat_last;
    logic              hit_any;
    logic              inv_any;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  lookup_way;
    logic [WAY_W-1:0]  old_age;

    assign cur_idx       = cur_addr[IDX_W-1:0];
    assign cur_tag       = cur_addr[ADDR_W-1:IDX_W];
    assign lat_last      = (lat_cnt == CNT_W'(MEM_LAT - 1));
    assign bus.req_ready = (state == IDLE);

    // Descending scan so the lowest-index invalid way wins the victim choice.
    always_comb begin
        hit_any = 1'b0;
        inv_any = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[cur_idx][w] && tag[cur_idx][w] == cur_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[cur_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age[cur_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
        victim     = inv_any ? inv_way : lru_way;
        lookup_way = hit_any ? hit_way : victim;
    end

    // Installing into an empty way ages it as if it were the oldest.
    assign old_age = valid[cur_idx][way_sel] ? age[cur_idx][way_sel] : WAY_W'(WAYS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.req_valid) next_state = LOOKUP;
            LOOKUP: begin
                if (hit_any)                                          next_state = RESPOND;
                else if (valid[cur_idx][victim] && dirty[cur_idx][victim]) next_state = WRITEBACK;
                else if (cur_write)                                   next_state = RESPOND;
                else                                                  next_state = FILL;
            end
            WRITEBACK: if (lat_last) next_state = cur_write ? RESPOND : FILL;
            FILL:      if (lat_last) next_state = RESPOND;
            RESPOND:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The victim write-back only reaches RAM on its final latency cycle, so a reset
    // before then leaves the old RAM word in place.
    always_ff @(posedge clk) begin
        if (state == WRITEBACK && lat_last)
            mem[{tag[cur_idx][way_sel], cur_idx}] <= data[cur_idx][way_sel];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tag[s][w]   <= '0;
                    data[s][w]  <= '0;
                    age[s][w]   <= '0;
                end
            end
            cur_write      <= 1'b0;
            cur_addr       <= '0;
            cur_wdata      <= '0;
            way_sel        <= '0;
            hit_reg        <= 1'b0;
            lat_cnt        <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_hit   <= 1'b0;
        end else begin
            bus.resp_valid <= (state == RESPOND);

            if (state == IDLE && bus.req_valid) begin
                cur_write <= bus.req_write;
                cur_addr  <= bus.req_addr;
                cur_wdata <= bus.req_wdata;
            end

            if ((state == WRITEBACK || state == FILL) && !lat_last) lat_cnt <= lat_cnt + 1'b1;
            else                                                    lat_cnt <= '0;

            if (state == LOOKUP) begin
                way_sel <= lookup_way;
                hit_reg <= hit_any;
                if (hit_any) begin
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
            end

            if (state == FILL && lat_last) data[cur_idx][way_sel] <= mem[cur_addr];

            if (state == RESPOND) begin
                valid[cur_idx][way_sel] <= 1'b1;
                tag[cur_idx][way_sel]   <= cur_tag;
                if (cur_write) begin
                    data[cur_idx][way_sel]  <= cur_wdata;
                    dirty[cur_idx][way_sel] <= 1'b1;
                    bus.resp_rdata          <= cur_wdata;
                end else begin
                    if (!hit_reg) dirty[cur_idx][way_sel] <= 1'b0;
                    bus.resp_rdata <= data[cur_idx][way_sel];
                end
                bus.resp_hit <= hit_reg;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way_sel)         age[cur_idx][w] <= '0;
                    else if (age[cur_idx][w] < old_age) age[cur_idx][w] <= age[cur_idx][w] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Scoreboard bench for cache_nway_wb: a 2-way and a 4-way instance share clock and reset.
module tb_cache_nway_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hit2, miss2, hit4, miss4;

    cache_nway_wb_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();
    cache_nway_wb_if #(.ADDR_W(8), .DATA_W(8)) bus4 ();

    cache_nway_wb #(.ADDR_W(8), .DATA_W(8), .SETS(4), .WAYS(2), .MEM_LAT(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .hit_count(hit2), .miss_count(miss2)
    );
    cache_nway_wb #(.ADDR_W(8), .DATA_W(8), .SETS(4), .WAYS(4), .MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .hit_count(hit4), .miss_count(miss4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       hit;
        int         lat;
        int         hits;
        int         misses;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       hit;
        int         lat;
        int         hits;
        int         misses;
        int         acc;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    exp_t e2, e4;
    vec_t vecs[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responses are matched in order against what each request was predicted to return.
    always @(negedge clk) begin
        if (bus2.resp_valid === 1'b1) begin
            if (q2.size() == 0) checkOutput("unexpected_resp_w2", 1, 0);
            else begin
                e2 = q2.pop_front();
                checkOutput("rdata_w2",   bus2.resp_rdata, e2.rdata);
                checkOutput("hit_w2",     bus2.resp_hit, e2.hit);
                checkOutput("latency_w2", cyc - e2.acc, e2.lat);
                checkOutput("hits_w2",    hit2, e2.hits);
                checkOutput("misses_w2",  miss2, e2.misses);
            end
        end
        if (bus4.resp_valid === 1'b1) begin
            if (q4.size() == 0) checkOutput("unexpected_resp_w4", 1, 0);
            else begin
                e4 = q4.pop_front();
                checkOutput("rdata_w4",   bus4.resp_rdata, e4.rdata);
                checkOutput("hit_w4",     bus4.resp_hit, e4.hit);
                checkOutput("latency_w4", cyc - e4.acc, e4.lat);
                checkOutput("hits_w4",    hit4, e4.hits);
                checkOutput("misses_w4",  miss4, e4.misses);
            end
        end
    end

    task automatic drive(input logic sel, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (sel) begin
            bus4.req_valid = v; bus4.req_write = w; bus4.req_addr = a; bus4.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic waitDrain(input logic sel);
        int n = 0;
        while ((sel ? q4.size() : q2.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checkOutput("resp_timeout", sel ? q4.size() : q2.size(), 0);
            if (sel) q4.delete(); else q2.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while ((v.sel ? bus4.req_ready : bus2.req_ready) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        drive(v.sel, 1'b1, v.write, v.addr, v.wdata);
        @(negedge clk);
        drive(v.sel, 1'b0, 1'b0, 8'h00, 8'h00);
        e = '{rdata: v.rdata, hit: v.hit, lat: v.lat, hits: v.hits, misses: v.misses, acc: cyc};
        if (v.sel) q4.push_back(e); else q2.push_back(e);
        waitDrain(v.sel);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   acc;
        exp_t e;

        // sel write addr wdata rdata hit lat hits misses
        vecs.push_back('{1'b0, 1'b0, 8'hAC, 8'h00, 8'hAC, 1'b0,  6, 0, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAC, 8'hF0, 8'hF0, 1'b1,  2, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 8'hAC, 8'h00, 8'hF0, 1'b1,  2, 2, 1});
        vecs.push_back('{1'b0, 1'b0, 8'hBC, 8'h00, 8'hBC, 1'b0,  6, 2, 2});
        vecs.push_back('{1'b0, 1'b0, 8'hCC, 8'h00, 8'hCC, 1'b0, 10, 2, 3});
        vecs.push_back('{1'b0, 1'b0, 8'hAC, 8'h00, 8'hF0, 1'b0,  6, 2, 4});
        vecs.push_back('{1'b0, 1'b1, 8'hDC, 8'h5A, 8'h5A, 1'b1,  2, 4, 5});
        vecs.push_back('{1'b0, 1'b0, 8'hAC, 8'h00, 8'hF0, 1'b1,  2, 5, 5});
        vecs.push_back('{1'b0, 1'b0, 8'hDC, 8'h00, 8'hDC, 1'b0,  6, 0, 1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  6, 0, 1});
        vecs.push_back('{1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 1'b0,  6, 0, 2});
        vecs.push_back('{1'b1, 1'b0, 8'h08, 8'h00, 8'h08, 1'b0,  6, 0, 3});
        vecs.push_back('{1'b1, 1'b0, 8'h0C, 8'h00, 8'h0C, 1'b0,  6, 0, 4});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,  2, 1, 4});
        vecs.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0,  6, 1, 5});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,  2, 2, 5});
        vecs.push_back('{1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 1'b0,  6, 2, 6});

        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",      bus2.req_ready, 1);
        checkOutput("rst_resp_valid", bus2.resp_valid, 0);
        checkOutput("rst_resp_rdata", bus2.resp_rdata, 0);
        checkOutput("rst_resp_hit",   bus2.resp_hit, 0);
        checkOutput("rst_hits",       hit2, 0);
        checkOutput("rst_misses",     miss2, 0);
        reset = 1'b0;

        for (int i = 0; i <= 5; i++) applyStimulus(vecs[i]);

        // Request held valid across a miss; the new address is taken only in the response cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'hDC, 8'h00);
        @(negedge clk);
        acc = cyc;
        bus2.req_addr = 8'hAC;
        e = '{rdata: 8'hDC, hit: 1'b0, lat: 6, hits: 2, misses: 5, acc: acc};
        q2.push_back(e);
        e = '{rdata: 8'hF0, hit: 1'b1, lat: 2, hits: 3, misses: 5, acc: acc + 7};
        q2.push_back(e);
        n = 0;
        while (bus2.resp_valid !== 1'b1 && n < 50) begin
            checkOutput("hold_ready_low", bus2.req_ready, 0);
            @(negedge clk);
            n++;
        end
        checkOutput("ready_in_resp_cycle", bus2.req_ready, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        waitDrain(1'b0);

        for (int i = 6; i <= 7; i++) applyStimulus(vecs[i]);

        // Reset in the second cycle of a dirty write-back of line 0xDC.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'hEC, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("wb_ready_low", bus2.req_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_resp_valid", bus2.resp_valid, 0);
        checkOutput("abort_hits",       hit2, 0);
        checkOutput("abort_misses",     miss2, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", bus2.req_ready, 1);
        checkOutput("ram_unchanged",  dut2.mem[8'hDC], 8'hDC);
        repeat (8) @(negedge clk);
        applyStimulus(vecs[8]);

        for (int i = 9; i <= 16; i++) applyStimulus(vecs[i]);

        repeat (4) @(negedge clk);
        checkOutput("queues_empty", q2.size() + q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
